// File: rtl/bpu_resolve_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bpu_resolve_ctrl_pkg
// Shared types for the branch-resolution controller:
//   bpu_upd_t       one predictor update record {pc, taken, target}
//   bpu_rs_state_t  resolution FSM states
//   bpu_correct_pc  next PC implied by a resolved branch
// ---------------------------------------------------------------------------
package bpu_resolve_ctrl_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } bpu_upd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REDIR = 2'd1,
      DRAIN = 2'd2
   } bpu_rs_state_t;

   // Fall-through is pc+4; the add wraps modulo 2^32 by construction.
   function automatic logic [31:0] bpu_correct_pc(input logic [31:0] pc,
                                                  input logic        taken,
                                                  input logic [31:0] target);
      return taken ? target : (pc + 32'd4);
   endfunction

endpackage

// File: rtl/bpu_resolve_ctrl_if.sv
// ---------------------------------------------------------------------------
// bpu_resolve_ctrl_if
// Bundle between the execute stage / fetch unit / BTB and the resolution
// controller.
//   ex_*            resolved branch from execute (ex_stall back-pressures it)
//   flush           squash IF/ID
//   redirect_*      one-shot fetch redirect
//   upd_*           BTB update channel, valid/ready
//   br_cnt/mis_cnt  performance counters
// modport master : the controller itself
// modport slave  : the surrounding pipeline / BTB
// ---------------------------------------------------------------------------
interface bpu_resolve_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             ex_valid;
   logic             ex_is_br;
   logic [31:0]      ex_pc;
   logic             ex_pred_taken;
   logic [31:0]      ex_pred_target;
   logic             ex_act_taken;
   logic [31:0]      ex_act_target;
   logic             ex_stall;
   logic             flush;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             upd_valid;
   logic             upd_ready;
   logic [31:0]      upd_pc;
   logic             upd_taken;
   logic [31:0]      upd_target;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] mis_cnt;

   modport master (
      input  ex_valid, ex_is_br, ex_pc, ex_pred_taken, ex_pred_target,
             ex_act_taken, ex_act_target, upd_ready,
      output ex_stall, flush, redirect_valid, redirect_pc,
             upd_valid, upd_pc, upd_taken, upd_target, br_cnt, mis_cnt
   );

   modport slave (
      output ex_valid, ex_is_br, ex_pc, ex_pred_taken, ex_pred_target,
             ex_act_taken, ex_act_target, upd_ready,
      input  ex_stall, flush, redirect_valid, redirect_pc,
             upd_valid, upd_pc, upd_taken, upd_target, br_cnt, mis_cnt
   );
endinterface

// File: rtl/bpu_resolve_ctrl_upd_fifo.sv
// ---------------------------------------------------------------------------
// bpu_upd_fifo
// Show-ahead synchronous FIFO of bpu_upd_t records.
//   clk, rst          clock, synchronous active-high reset (empties FIFO)
//   i_push, i_data    write request / record (ignored when full)
//   o_full            no free entry
//   i_pop             consume head (ignored when empty)
//   o_data, o_empty   head record / no valid entry
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module bpu_upd_fifo
   import bpu_resolve_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_push,
   input  bpu_upd_t i_data,
   output logic     o_full,
   input  logic     i_pop,
   output bpu_upd_t o_data,
   output logic     o_empty
);

   localparam int AW = $clog2(DEPTH);

   bpu_upd_t     r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         w_push;
   logic         w_pop;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

   // Storage has no reset; emptiness is tracked purely by the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/bpu_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// bpu_resolve_ctrl
// Resolves branches from execute, detects mispredictions, issues a one-cycle
// fetch redirect followed by a FLUSH_CYC-cycle IF/ID flush, queues BTB
// updates and counts resolved / mispredicted branches.
//   clk, rst  clock, synchronous active-high reset
//   io_bus    bpu_resolve_ctrl_if.master (execute, redirect, update, counters)
// ---------------------------------------------------------------------------
module bpu_resolve_ctrl
   import bpu_resolve_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int FLUSH_CYC  = 2,
   parameter int CNT_W      = 32
) (
   input logic                clk,
   input logic                rst,
   bpu_resolve_ctrl_if.master io_bus
);

   localparam int             DCW        = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [DCW-1:0] DRAIN_INIT = DCW'(FLUSH_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   bpu_rs_state_t    r_state, w_state_next;
   logic [DCW-1:0]   r_drain_cnt, w_drain_cnt_next;
   logic [31:0]      r_redirect_pc;
   logic [CNT_W-1:0] r_br_cnt;
   logic [CNT_W-1:0] r_mis_cnt;

   logic     w_br_present;
   logic     w_res;
   logic     w_mis;
   logic     w_flush;
   logic     w_redir;
   logic     w_full;
   logic     w_empty;
   logic     w_pop;
   bpu_upd_t w_enq;
   bpu_upd_t w_head;

   // Branches are only considered in IDLE; in REDIR/DRAIN they are wrong-path.
   assign w_br_present = io_bus.ex_valid & io_bus.ex_is_br & (r_state == IDLE);
   assign w_res        = w_br_present & ~w_full;
   assign w_mis        = (io_bus.ex_pred_taken != io_bus.ex_act_taken) |
                         (io_bus.ex_act_taken &
                          (io_bus.ex_pred_target != io_bus.ex_act_target));

   assign w_enq = '{pc: io_bus.ex_pc, taken: io_bus.ex_act_taken,
                    target: io_bus.ex_act_target};
   assign w_pop = ~w_empty & io_bus.upd_ready;

   bpu_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_res),
      .i_data  (w_enq),
      .o_full  (w_full),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty)
   );

   always_comb begin
      w_state_next     = r_state;
      w_drain_cnt_next = r_drain_cnt;
      w_flush          = 1'b0;
      w_redir          = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_res && w_mis) w_state_next = REDIR;
         end
         REDIR: begin
            w_flush = 1'b1;
            w_redir = 1'b1;
            if (FLUSH_CYC == 1) begin
               w_state_next = IDLE;
            end else begin
               w_state_next     = DRAIN;
               w_drain_cnt_next = DRAIN_INIT;
            end
         end
         DRAIN: begin
            w_flush          = 1'b1;
            w_drain_cnt_next = r_drain_cnt - 1'b1;
            if (r_drain_cnt == DCW'(1)) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_drain_cnt   <= '0;
         r_redirect_pc <= '0;
         r_br_cnt      <= '0;
         r_mis_cnt     <= '0;
      end else begin
         r_state     <= w_state_next;
         r_drain_cnt <= w_drain_cnt_next;
         if (w_res && w_mis) begin
            r_redirect_pc <= bpu_correct_pc(io_bus.ex_pc, io_bus.ex_act_taken,
                                            io_bus.ex_act_target);
         end
         if (w_res && (r_br_cnt != CNT_MAX)) r_br_cnt <= r_br_cnt + 1'b1;
         if (w_res && w_mis && (r_mis_cnt != CNT_MAX)) r_mis_cnt <= r_mis_cnt + 1'b1;
      end
   end

   assign io_bus.ex_stall       = w_br_present & w_full;
   assign io_bus.flush          = w_flush;
   assign io_bus.redirect_valid = w_redir;
   assign io_bus.redirect_pc    = r_redirect_pc;
   assign io_bus.br_cnt         = r_br_cnt;
   assign io_bus.mis_cnt        = r_mis_cnt;

   // Head fields read as zero when empty so the port is clean out of reset.
   assign io_bus.upd_valid  = ~w_empty;
   assign io_bus.upd_pc     = w_empty ? 32'd0 : w_head.pc;
   assign io_bus.upd_taken  = ~w_empty & w_head.taken;
   assign io_bus.upd_target = w_empty ? 32'd0 : w_head.target;

endmodule

// File: tb/tb_bpu_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bpu_resolve_ctrl
// Directed table of cycles with hand-derived expectations, a randomized run
// against a queue-based reference model, and a counter saturation run on a
// second instance built with CNT_W=4 that shadows the main instance's inputs.
// ---------------------------------------------------------------------------
module tb_bpu_resolve_ctrl;

   localparam int DEPTH = 4;
   localparam int FC    = 2;
   localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bpu_resolve_ctrl_if #(.CNT_W(32)) m_if ();
   bpu_resolve_ctrl_if #(.CNT_W(4))  s_if ();

   assign s_if.ex_valid       = m_if.ex_valid;
   assign s_if.ex_is_br       = m_if.ex_is_br;
   assign s_if.ex_pc          = m_if.ex_pc;
   assign s_if.ex_pred_taken  = m_if.ex_pred_taken;
   assign s_if.ex_pred_target = m_if.ex_pred_target;
   assign s_if.ex_act_taken   = m_if.ex_act_taken;
   assign s_if.ex_act_target  = m_if.ex_act_target;
   assign s_if.upd_ready      = m_if.upd_ready;

   bpu_resolve_ctrl #(.FIFO_DEPTH(DEPTH), .FLUSH_CYC(FC), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .io_bus(m_if));

   bpu_resolve_ctrl #(.FIFO_DEPTH(DEPTH), .FLUSH_CYC(FC), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .io_bus(s_if));

   typedef struct {
      bit          v, br;
      logic [31:0] pc;
      bit          pt;
      logic [31:0] ptg;
      bit          at;
      logic [31:0] atg;
      bit          rdy, rs;
      bit          e_stall, e_flush, e_rv;
      logic [31:0] e_rpc;
      bit          e_uv;
      logic [31:0] e_upc;
      int          e_br, e_mis;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      bit          taken;
      logic [31:0] target;
   } mq_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: pending updates, remaining wrong-path cycles, counters.
   mq_t         m_q[$];
   int          m_busy = 0;
   longint      m_br   = 0;
   longint      m_mis  = 0;
   logic [31:0] m_rpc  = 32'd0;

   vec_t tab[29];

   function automatic vec_t mk(bit v, bit br, logic [31:0] pc, bit pt, logic [31:0] ptg,
                               bit at, logic [31:0] atg, bit rdy, bit rs,
                               bit st, bit fl, bit rv, logic [31:0] rpc,
                               bit uv, logic [31:0] upc, int bc, int mc);
      vec_t r;
      r.v = v; r.br = br; r.pc = pc; r.pt = pt; r.ptg = ptg; r.at = at; r.atg = atg;
      r.rdy = rdy; r.rs = rs;
      r.e_stall = st; r.e_flush = fl; r.e_rv = rv; r.e_rpc = rpc;
      r.e_uv = uv; r.e_upc = upc; r.e_br = bc; r.e_mis = mc;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic step(input vec_t r, input bit tabchk);
      bit  full, brn, res, mis;
      mq_t e;
      m_if.ex_valid       = r.v;
      m_if.ex_is_br       = r.br;
      m_if.ex_pc          = r.pc;
      m_if.ex_pred_taken  = r.pt;
      m_if.ex_pred_target = r.ptg;
      m_if.ex_act_taken   = r.at;
      m_if.ex_act_target  = r.atg;
      m_if.upd_ready      = r.rdy;
      rst                 = r.rs;
      @(negedge clk);
      full = (m_q.size() == DEPTH);
      brn  = r.v && r.br && (m_busy == 0);
      chk("stall",  32'(m_if.ex_stall),       32'(brn && full));
      chk("flush",  32'(m_if.flush),          32'(m_busy > 0));
      chk("redir",  32'(m_if.redirect_valid), 32'(m_busy == FC));
      chk("rpc",    m_if.redirect_pc,         m_rpc);
      chk("uvalid", 32'(m_if.upd_valid),      32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk("upc",     m_if.upd_pc,            m_q[0].pc);
         chk("utaken",  32'(m_if.upd_taken),    32'(m_q[0].taken));
         chk("utarget", m_if.upd_target,        m_q[0].target);
      end
      chk("brcnt",  m_if.br_cnt,  32'(m_br));
      chk("miscnt", m_if.mis_cnt, 32'(m_mis));
      if (tabchk) begin
         chk("t_stall",  32'(m_if.ex_stall),       32'(r.e_stall));
         chk("t_flush",  32'(m_if.flush),          32'(r.e_flush));
         chk("t_redir",  32'(m_if.redirect_valid), 32'(r.e_rv));
         chk("t_rpc",    m_if.redirect_pc,         r.e_rpc);
         chk("t_uvalid", 32'(m_if.upd_valid),      32'(r.e_uv));
         chk("t_upc",    m_if.upd_pc,              r.e_upc);
         chk("t_brcnt",  m_if.br_cnt,              32'(r.e_br));
         chk("t_miscnt", m_if.mis_cnt,             32'(r.e_mis));
      end
      $display("cyc=%0d rst=%0d v=%0d br=%0d pc=%h rdy=%0d stall=%0d flush=%0d redir=%0d rpc=%h upd_v=%0d upd_pc=%h br_cnt=%0d mis_cnt=%0d",
               cyc, r.rs, r.v, r.br, r.pc, r.rdy, m_if.ex_stall, m_if.flush,
               m_if.redirect_valid, m_if.redirect_pc, m_if.upd_valid, m_if.upd_pc,
               m_if.br_cnt, m_if.mis_cnt);
      @(posedge clk);
      if (r.rs) begin
         m_q.delete();
         m_busy = 0; m_br = 0; m_mis = 0; m_rpc = 32'd0;
      end else begin
         res = brn && !full;
         if ((m_q.size() > 0) && r.rdy) void'(m_q.pop_front());
         if (m_busy > 0) m_busy--;
         if (res) begin
            e.pc = r.pc; e.taken = r.at; e.target = r.atg;
            m_q.push_back(e);
            if (m_br < MAXC) m_br++;
            mis = (r.pt != r.at) || (r.at && (r.ptg != r.atg));
            if (mis) begin
               if (m_mis < MAXC) m_mis++;
               m_busy = FC;
               m_rpc  = r.at ? r.atg : r.pc + 32'd4;
            end
         end
      end
      cyc++;
      #1;
   endtask

   initial begin
      vec_t r;
      // v br pc pt ptg at atg rdy rs | stall flush redir rpc uv upc br mis
      tab[0]  = mk(1,1,'h100,0,0,0,0,1,0,       0,0,0,'h0,  0,'h0,   0,0);
      tab[1]  = mk(0,0,0,0,0,0,0,1,0,           0,0,0,'h0,  1,'h100, 1,0);
      tab[2]  = mk(1,1,'h200,0,0,1,'h80,0,0,    0,0,0,'h0,  0,'h0,   1,0);
      tab[3]  = mk(0,0,0,0,0,0,0,0,0,           0,1,1,'h80, 1,'h200, 2,1);
      tab[4]  = mk(0,0,0,0,0,0,0,0,0,           0,1,0,'h80, 1,'h200, 2,1);
      tab[5]  = mk(0,0,0,0,0,0,0,1,0,           0,0,0,'h80, 1,'h200, 2,1);
      tab[6]  = mk(1,1,'h3F0,1,'h400,1,'h480,1,0,0,0,0,'h80, 0,'h0,   2,1);
      tab[7]  = mk(1,1,'h500,0,0,1,'h520,1,0,   0,1,1,'h480,1,'h3F0, 3,2);
      tab[8]  = mk(1,1,'h600,0,0,1,'h640,1,0,   0,1,0,'h480,0,'h0,   3,2);
      tab[9]  = mk(0,0,0,0,0,0,0,1,0,           0,0,0,'h480,0,'h0,   3,2);
      tab[10] = mk(1,1,'h300,1,'h340,0,0,1,0,   0,0,0,'h480,0,'h0,   3,2);
      tab[11] = mk(0,0,0,0,0,0,0,1,0,           0,1,1,'h304,1,'h300, 4,3);
      tab[12] = mk(0,0,0,0,0,0,0,1,0,           0,1,0,'h304,0,'h0,   4,3);
      tab[13] = mk(0,0,0,0,0,0,0,1,0,           0,0,0,'h304,0,'h0,   4,3);
      tab[14] = mk(1,1,'h1000,0,0,0,0,0,0,      0,0,0,'h304,0,'h0,   4,3);
      tab[15] = mk(1,1,'h1004,0,0,0,0,0,0,      0,0,0,'h304,1,'h1000,5,3);
      tab[16] = mk(1,1,'h1008,0,0,0,0,0,0,      0,0,0,'h304,1,'h1000,6,3);
      tab[17] = mk(1,1,'h100C,0,0,0,0,0,0,      0,0,0,'h304,1,'h1000,7,3);
      tab[18] = mk(1,1,'h1010,0,0,0,0,0,0,      1,0,0,'h304,1,'h1000,8,3);
      tab[19] = mk(1,1,'h1010,0,0,0,0,1,0,      1,0,0,'h304,1,'h1000,8,3);
      tab[20] = mk(1,1,'h1010,0,0,0,0,1,0,      0,0,0,'h304,1,'h1004,8,3);
      tab[21] = mk(0,0,0,0,0,0,0,1,0,           0,0,0,'h304,1,'h1008,9,3);
      tab[22] = mk(0,0,0,0,0,0,0,1,0,           0,0,0,'h304,1,'h100C,9,3);
      tab[23] = mk(0,0,0,0,0,0,0,1,0,           0,0,0,'h304,1,'h1010,9,3);
      tab[24] = mk(0,0,0,0,0,0,0,1,0,           0,0,0,'h304,0,'h0,   9,3);
      tab[25] = mk(1,1,'h700,1,'h900,0,0,0,0,   0,0,0,'h304,0,'h0,   9,3);
      tab[26] = mk(0,0,0,0,0,0,0,0,1,           0,1,1,'h704,1,'h700,10,4);
      tab[27] = mk(0,0,0,0,0,0,0,0,0,           0,0,0,'h0,  0,'h0,   0,0);
      tab[28] = mk(0,0,0,0,0,0,0,0,0,           0,0,0,'h0,  0,'h0,   0,0);

      // Reset.
      r = mk(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0);
      m_if.ex_valid = 0; m_if.ex_is_br = 0; m_if.ex_pc = 0;
      m_if.ex_pred_taken = 0; m_if.ex_pred_target = 0;
      m_if.ex_act_taken = 0; m_if.ex_act_target = 0; m_if.upd_ready = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_stall",  32'(m_if.ex_stall),       32'd0);
      chk("rst_flush",  32'(m_if.flush),          32'd0);
      chk("rst_redir",  32'(m_if.redirect_valid), 32'd0);
      chk("rst_rpc",    m_if.redirect_pc,         32'd0);
      chk("rst_uvalid", 32'(m_if.upd_valid),      32'd0);
      chk("rst_upc",    m_if.upd_pc,              32'd0);
      chk("rst_brcnt",  m_if.br_cnt,              32'd0);
      chk("rst_miscnt", m_if.mis_cnt,             32'd0);
      @(posedge clk);
      #1;

      // Directed table.
      for (int i = 0; i < 29; i++) step(tab[i], 1'b1);

      // Randomized run against the model.
      for (int i = 0; i < 300; i++) begin
         r = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
         r.v   = ($urandom_range(0, 3) != 0);
         r.br  = ($urandom_range(0, 3) != 0);
         r.pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         r.at  = $urandom_range(0, 1) == 1;
         r.atg = $urandom() & 32'hFFFF_FFFC;
         r.pt  = ($urandom_range(0, 3) != 0) ? r.at : !r.at;
         r.ptg = ($urandom_range(0, 3) != 0) ? r.atg : ($urandom() & 32'hFFFF_FFFC);
         r.rdy = $urandom_range(0, 1) == 1;
         r.rs  = ($urandom_range(0, 99) == 0);
         step(r, 1'b0);
      end

      // Saturation: 16 back-to-back mispredicts, then 2 more.
      r = mk(0,0,0,0,0,0,0,1,1, 0,0,0,0,0,0,0,0);
      step(r, 1'b0);
      r = mk(1,1,'h40,0,0,1,'h80,1,0, 0,0,0,0,0,0,0,0);
      for (int i = 0; i < 16 * (FC + 1); i++) step(r, 1'b0);
      chk("sat_br16",  32'(s_if.br_cnt),  32'd15);
      chk("sat_mis16", 32'(s_if.mis_cnt), 32'd15);
      chk("wide_br16", m_if.br_cnt,       32'd16);
      for (int i = 0; i < 2 * (FC + 1); i++) step(r, 1'b0);
      chk("sat_br_hold",  32'(s_if.br_cnt),  32'd15);
      chk("sat_mis_hold", 32'(s_if.mis_cnt), 32'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
